// File: rtl/db_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port.
// One access at a time: IDLE (arbitrate + latch) -> BUSY (wait for db_ready or
// timeout) -> RESP (one-cycle completion pulse to the granted master).
module db_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          res,

  // Master 0
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m0_dataOut,
  input  logic [1:0]    m0_accessType,
  input  logic [1:0]    m0_memLen,
  input  logic          m0_signed,
  output logic          m0_ready,
  output logic [AW-1:0] m0_dataIn,
  output logic          m0_err,

  // Master 1
  input  logic [AW-1:0] m1_addr,
  input  logic [AW-1:0] m1_dataOut,
  input  logic [1:0]    m1_accessType,
  input  logic [1:0]    m1_memLen,
  input  logic          m1_signed,
  output logic          m1_ready,
  output logic [AW-1:0] m1_dataIn,
  output logic          m1_err,

  // Memory side
  output logic [AW-1:0] db_addr,
  output logic [AW-1:0] db_dataOut,
  output logic [1:0]    db_accessType,
  output logic [1:0]    db_memLen,
  output logic          db_signed,
  input  logic          db_ready,
  input  logic [AW-1:0] db_dataIn
);

  localparam logic [1:0] AccNone  = 2'b00;
  localparam logic [1:0] AccRead  = 2'b01;
  localparam logic [1:0] AccExec  = 2'b11;

  // Last counter value that may still wait; reaching it without db_ready aborts.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;      // 0: m0 has priority, 1: m1 has priority
  logic          grant_q, grant_d;  // master owning the current access
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    acc_q, acc_d;      // access type kept for the response phase

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    len_q, len_d;
  logic          sgn_q, sgn_d;

  logic          req0, req1, win;
  logic [AW-1:0] sel_addr, sel_wdata;
  logic [1:0]    sel_type, sel_len;
  logic          sel_sgn;
  logic [AW-1:0] rsp_data;

  // Request decode and round-robin winner; a sole requester always wins.
  always_comb begin
    req0 = (m0_accessType != AccNone);
    req1 = (m1_accessType != AccNone);
    win  = (req0 && req1) ? ptr_q : req1;
    if (win) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_dataOut;
      sel_type  = m1_accessType;
      sel_len   = m1_memLen;
      sel_sgn   = m1_signed;
    end else begin
      sel_addr  = m0_addr;
      sel_wdata = m0_dataOut;
      sel_type  = m0_accessType;
      sel_len   = m0_memLen;
      sel_sgn   = m0_signed;
    end
  end

  // Next-state logic: grant in IDLE, wait/timeout in BUSY, pointer update in RESP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    len_d   = len_q;
    sgn_d   = sgn_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = win;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          type_d  = sel_type;
          len_d   = sel_len;
          sgn_d   = sel_sgn;
          acc_d   = sel_type;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (db_ready) begin
          err_d   = 1'b0;
          type_d  = AccNone;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          type_d  = AccNone;
          state_d = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        ptr_d   = ~grant_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and request registers; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      acc_q   <= AccNone;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= AccNone;
      len_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      len_q   <= len_d;
      sgn_q   <= sgn_d;
    end
  end

  // Memory-side outputs come straight from the latched request.
  always_comb begin
    db_addr       = addr_q;
    db_dataOut    = wdata_q;
    db_accessType = type_q;
    db_memLen     = len_q;
    db_signed     = sgn_q;
  end

  // Completion outputs: only the granted master sees anything, and only in RESP.
  always_comb begin
    m0_ready  = 1'b0;
    m0_dataIn = '0;
    m0_err    = 1'b0;
    m1_ready  = 1'b0;
    m1_dataIn = '0;
    m1_err    = 1'b0;
    // Read data is only meaningful for a successful read or fetch.
    rsp_data  = (!err_q && (acc_q == AccRead || acc_q == AccExec)) ? db_dataIn : '0;
    if (state_q == StResp) begin
      if (grant_q) begin
        m1_ready  = 1'b1;
        m1_dataIn = rsp_data;
        m1_err    = err_q;
      end else begin
        m0_ready  = 1'b1;
        m0_dataIn = rsp_data;
        m0_err    = err_q;
      end
    end
  end

endmodule

// File: doc/db_arbiter.md
DB_ARBITER -- requirements
Module: db_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles a bus access may wait for db_ready before abort (1..65535).
REQ-002 SHALL have parameter AW, default 32, address/data width.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port res  in  1  reset, synchronous, active-high.
REQ-005 SHALL have, for k in {0,1}: mk_addr in AW; mk_dataOut in AW (write data); mk_accessType in 2 (00 NONE, 01 R, 10 W, 11 X); mk_memLen in 2 (00 byte, 01 half, 10 word); mk_signed in 1.
REQ-006 SHALL have, for k in {0,1}: mk_ready out 1 (one-cycle completion pulse); mk_dataIn out AW (read data, valid only while mk_ready=1); mk_err out 1 (timeout flag, valid only while mk_ready=1).
REQ-007 SHALL have memory side: db_addr out AW; db_dataOut out AW; db_accessType out 2; db_memLen out 2; db_signed out 1; db_ready in 1; db_dataIn in AW.
REQ-008 SHALL encode a master request as mk_accessType != NONE; a master holds all mk_* request inputs stable until its mk_ready pulse.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-010 IDLE: no request -> stay; any request -> latch winner's addr/dataOut/accessType/memLen/signed into db_* registers, record grant, clear wait counter, -> BUSY.
REQ-011 Arbitration SHALL be round-robin: priority pointer starts at m0; after a master completes (incl. timeout), pointer moves to the other master; sole requester always wins.
REQ-012 BUSY: db_* outputs SHALL present the latched request unchanged; if db_ready=1 -> RESP with err=0; else counter+1, and when counter reaches TIMEOUT-1 without db_ready -> RESP with err=1.
REQ-013 Memory contract: db_ready sampled high at an edge completes the access; db_dataIn is valid during the following cycle.
REQ-014 On entering RESP, db_accessType SHALL return to NONE (other db_* may hold last value).
REQ-015 RESP (exactly one cycle): granted mk_ready=1; mk_dataIn = db_dataIn (pass-through) if err=0 and access was R or X, else 0; mk_err = err flag; -> IDLE.
REQ-016 Non-granted master, and all masters outside RESP: mk_ready=0, mk_dataIn=0, mk_err=0.
REQ-017 Requests SHALL be sampled only in IDLE; a request arriving during BUSY/RESP waits; minimum back-to-back spacing is 3 cycles per access (IDLE, BUSY, RESP) with zero-wait memory.
REQ-018 Latency: request present in IDLE at edge N -> db_accessType valid after N; db_ready at edge N+1 -> mk_ready high cycle after N+1.
REQ-019 Wait counter SHALL be 16 bits, saturating, cleared on each grant.
REQ-020 db_ready while in IDLE or RESP SHALL be ignored.

Reset
REQ-021 res=1 at an edge SHALL force IDLE, pointer=m0, counter=0, err=0, db_accessType=NONE, db_addr=db_dataOut=0, db_memLen=0, db_signed=0, all mk_ready/mk_err/mk_dataIn=0, from any state incl. mid-BUSY; the aborted access produces no mk_ready.
REQ-022 First arbitration after reset release SHALL occur at the first edge with res=0.

Verification
REQ-023 Single read: m0 R addr 0x100, mem db_ready=1, db_dataIn=0xDEADBEEF next cycle -> db_accessType=01/db_addr=0x100 one cycle, m0_ready one cycle with m0_dataIn=0xDEADBEEF, m0_err=0.
REQ-024 Contention: m0 W 0x10 and m1 R 0x20 both raised in IDLE after reset -> m0 served first, then m1; with both continuously requesting, grants alternate m0,m1,m0,m1.
REQ-025 Wait states: m1 X 0x40, db_ready held low 5 cycles -> db_* stable for 6 BUSY cycles, m1_ready once, err=0, m0 outputs stay 0.
REQ-026 Timeout with TIMEOUT=4: db_ready never asserted -> exactly 4 BUSY cycles, then m0_ready=1, m0_err=1, m0_dataIn=0, db_accessType=NONE.
REQ-027 Reset mid-BUSY: res=1 during m1 access -> next cycle all outputs zero/NONE, no m1_ready; after release pending m0 request granted first.
REQ-028 Write data: m1 W 0x80 data 0x12345678 memLen=10 -> db_dataOut=0x12345678, db_memLen=10 throughout BUSY, m1_dataIn=0 on completion.
